// File: rtl/cordic_gen_if.sv
// Operand write channel and result read channel of the cordic_gen engine.
interface cordic_gen_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic          wr_axy_p;
  logic          mode_p;
  logic [AW-1:0] a_p;
  logic [DW-1:0] x_p;
  logic [DW-1:0] y_p;
  logic          wok_axy_p;
  logic          rd_nxy_p;
  logic [DW-1:0] nx_p;
  logic [DW-1:0] ny_p;
  logic [AW-1:0] na_p;
  logic          rok_nxy_p;

  modport master (
    output wr_axy_p, mode_p, a_p, x_p, y_p, rd_nxy_p,
    input  wok_axy_p, nx_p, ny_p, na_p, rok_nxy_p
  );

  modport slave (
    input  wr_axy_p, mode_p, a_p, x_p, y_p, rd_nxy_p,
    output wok_axy_p, nx_p, ny_p, na_p, rok_nxy_p
  );
endinterface

// File: rtl/cordic_gen.sv
// Iterative CORDIC engine: rotation or vectoring, one micro-rotation per cycle,
// shift-add gain compensation and saturated, registered results.
module cordic_gen #(
  parameter int DW    = 8,
  parameter int AW    = 10,
  parameter int NITER = 8
) (
  input  logic        ck,
  input  logic        raz,
  cordic_gen_if.slave bus
);
  localparam int IW  = DW + 9;
  localparam int AAW = AW + 2;
  localparam logic [3:0]            ILAST = 4'(NITER - 1);
  localparam logic signed [AAW-1:0] QTR   = {{(AAW-8){1'b0}}, 8'd201};
  localparam logic signed [AAW-1:0] HALF  = {{(AAW-9){1'b0}}, 9'd402};
  localparam logic signed [IW-8:0]  XMAX  = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [IW-8:0]  XMIN  = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [AAW-1:0] AMAX  = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [AAW-1:0] AMIN  = {3'b111, {(AW-1){1'b0}}};

  typedef enum logic [5:0] {
    GET   = 6'b000001,
    NORM  = 6'b000010,
    CALC  = 6'b000100,
    MKC   = 6'b001000,
    PLACE = 6'b010000,
    PUT   = 6'b100000
  } state_t;

  state_t                state, state_nx;
  logic                  mode, mode_nx;
  logic [1:0]            quad, quad_nx;
  logic [3:0]            i, i_nx;
  logic signed [IW-1:0]  x, x_nx, y, y_nx, xkc, xkc_nx, ykc, ykc_nx;
  logic signed [AAW-1:0] a, a_nx;
  logic [DW-1:0]         nx, nx_nx, ny, ny_nx;
  logic [AW-1:0]         na, na_nx;
  logic signed [IW-1:0]  xs, ys, px, py;
  logic signed [AAW-1:0] tz, a_sub;

  // atan(2^-i) in units of 2^-7 rad
  function automatic logic [6:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 7'd100;
      4'd1:    atan_lut = 7'd59;
      4'd2:    atan_lut = 7'd31;
      4'd3:    atan_lut = 7'd16;
      4'd4:    atan_lut = 7'd8;
      4'd5:    atan_lut = 7'd4;
      4'd6:    atan_lut = 7'd2;
      4'd7:    atan_lut = 7'd1;
      default: atan_lut = 7'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] sat_xy(input logic signed [IW-1:0] v);
    logic signed [IW-8:0] ip;
    ip = v[IW-1:7];
    if (ip > XMAX)      sat_xy = {1'b0, {(DW-1){1'b1}}};
    else if (ip < XMIN) sat_xy = {1'b1, {(DW-1){1'b0}}};
    else                sat_xy = ip[DW-1:0];
  endfunction

  function automatic logic [AW-1:0] sat_a(input logic signed [AAW-1:0] v);
    if (v > AMAX)      sat_a = {1'b0, {(AW-1){1'b1}}};
    else if (v < AMIN) sat_a = {1'b1, {(AW-1){1'b0}}};
    else               sat_a = v[AW-1:0];
  endfunction

  // Next-state and datapath update for every phase of a transaction
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    quad_nx  = quad;
    i_nx     = i;
    x_nx     = x;
    y_nx     = y;
    a_nx     = a;
    xkc_nx   = xkc;
    ykc_nx   = ykc;
    nx_nx    = nx;
    ny_nx    = ny;
    na_nx    = na;
    xs       = x >>> i;
    ys       = y >>> i;
    tz       = {{(AAW-7){1'b0}}, atan_lut(i)};
    a_sub    = a - QTR;
    px       = xkc;
    py       = ykc;
    case (state)
      GET: begin
        if (bus.wr_axy_p) begin
          a_nx     = {2'b00, bus.a_p};
          x_nx     = {{2{bus.x_p[DW-1]}}, bus.x_p, 7'b0000000};
          y_nx     = {{2{bus.y_p[DW-1]}}, bus.y_p, 7'b0000000};
          mode_nx  = bus.mode_p;
          quad_nx  = 2'd0;
          i_nx     = 4'd0;
          state_nx = NORM;
        end else begin
          state_nx = GET;
        end
      end
      NORM: begin
        if (mode) begin
          // fold the left half-plane onto the right, pre-loading +/-pi
          if (x[IW-1]) begin
            x_nx = -x;
            y_nx = -y;
            a_nx = y[IW-1] ? -HALF : HALF;
          end else begin
            a_nx = {AAW{1'b0}};
          end
          state_nx = CALC;
        end else if (!a_sub[AAW-1]) begin
          a_nx     = a_sub;
          quad_nx  = quad + 2'd1;
          state_nx = NORM;
        end else begin
          state_nx = CALC;
        end
      end
      CALC: begin
        if (mode ? !y[IW-1] : a[AAW-1]) begin
          x_nx = x + ys;
          y_nx = y - xs;
          a_nx = a + tz;
        end else begin
          x_nx = x - ys;
          y_nx = y + xs;
          a_nx = a - tz;
        end
        if (i == ILAST) begin
          i_nx     = 4'd0;
          state_nx = MKC;
        end else begin
          i_nx = i + 4'd1;
        end
      end
      MKC: begin
        case (i)
          4'd0: begin
            xkc_nx = (x >>> 4'd7) + (x >>> 4'd5);
            ykc_nx = (y >>> 4'd7) + (y >>> 4'd5);
            i_nx   = 4'd1;
          end
          4'd1: begin
            xkc_nx = xkc + (x >>> 4'd4);
            ykc_nx = ykc + (y >>> 4'd4);
            i_nx   = 4'd2;
          end
          default: begin
            xkc_nx   = xkc + (x >>> 4'd1);
            ykc_nx   = ykc + (y >>> 4'd1);
            i_nx     = 4'd0;
            state_nx = PLACE;
          end
        endcase
      end
      PLACE: begin
        if (mode) begin
          px = xkc;
          py = ykc;
        end else begin
          case (quad)
            2'd0:    begin px = xkc;  py = ykc;  end
            2'd1:    begin px = -ykc; py = xkc;  end
            2'd2:    begin px = -xkc; py = -ykc; end
            default: begin px = ykc;  py = -xkc; end
          endcase
        end
        nx_nx    = sat_xy(px);
        ny_nx    = sat_xy(py);
        na_nx    = sat_a(a);
        state_nx = PUT;
      end
      PUT: begin
        if (bus.rd_nxy_p) state_nx = GET;
        else              state_nx = PUT;
      end
      default: state_nx = GET;
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge ck) begin
    if (!raz) begin
      state <= GET;
      mode  <= 1'b0;
      quad  <= 2'd0;
      i     <= 4'd0;
      x     <= {IW{1'b0}};
      y     <= {IW{1'b0}};
      a     <= {AAW{1'b0}};
      xkc   <= {IW{1'b0}};
      ykc   <= {IW{1'b0}};
      nx    <= {DW{1'b0}};
      ny    <= {DW{1'b0}};
      na    <= {AW{1'b0}};
    end else begin
      state <= state_nx;
      mode  <= mode_nx;
      quad  <= quad_nx;
      i     <= i_nx;
      x     <= x_nx;
      y     <= y_nx;
      a     <= a_nx;
      xkc   <= xkc_nx;
      ykc   <= ykc_nx;
      nx    <= nx_nx;
      ny    <= ny_nx;
      na    <= na_nx;
    end
  end

  assign bus.wok_axy_p = (state == GET);
  assign bus.rok_nxy_p = (state == PUT);
  assign bus.nx_p      = nx;
  assign bus.ny_p      = ny;
  assign bus.na_p      = na;
endmodule

// File: tb/tb_cordic_gen.sv
// Self-checking bench for cordic_gen: directed cases plus random transactions
// compared against an ideal trigonometric model with a small tolerance.
module tb_cordic_gen;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int NITER = 8;

  logic ck = 1'b0;
  logic raz;
  int   checks = 0;
  int   errors = 0;
  real  gain;

  cordic_gen_if #(.DW(DW), .AW(AW)) bus ();
  cordic_gen #(.DW(DW), .AW(AW), .NITER(NITER)) dut (.ck(ck), .raz(raz), .bus(bus));

  always #5 ck = ~ck;

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  function automatic int clip(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = (obs > exp) ? obs - exp : exp - obs;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  // Ideal result: exact rotation / polar conversion scaled by the engine's net gain
  task automatic model(input bit md, input int a, input int x, input int y,
                       output int ex, output int ey, output int ea);
    real t, rx, ry;
    if (!md) begin
      t  = real'(a) / 128.0;
      rx = gain * (real'(x) * $cos(t) - real'(y) * $sin(t));
      ry = gain * (real'(x) * $sin(t) + real'(y) * $cos(t));
      ea = 0;
    end else begin
      rx = gain * $sqrt(real'(x * x + y * y));
      ry = 0.0;
      ea = rnd($atan2(real'(y), real'(x)) * 128.0);
    end
    ex = clip(rnd(rx), -128, 127);
    ey = clip(rnd(ry), -128, 127);
  endtask

  task automatic run_txn(input string tag, input bit md, input int a, input int x, input int y,
                         input int tol_xy, input int tol_a, input bit inject, input int hold,
                         output int nxo);
    int ex, ey, ea, lat, exp_lat, nyo, nao, w;
    bit done;
    model(md, a, x, y, ex, ey, ea);
    exp_lat = md ? NITER + 6 : a / 201 + NITER + 6;
    w = 0;
    @(negedge ck);
    while (bus.wok_axy_p !== 1'b1 && w < 50) begin
      @(negedge ck);
      w++;
    end
    chk_eq({tag, "_wok"}, int'(bus.wok_axy_p), 1);
    bus.wr_axy_p = 1'b1;
    bus.mode_p   = md;
    bus.a_p      = AW'(a);
    bus.x_p      = DW'(x);
    bus.y_p      = DW'(y);
    lat  = 0;
    done = 1'b0;
    // latency counted inclusive of the accepting edge
    while (!done && lat < 200) begin
      @(posedge ck);
      #1;
      lat++;
      if (inject && lat == 4) begin
        bus.wr_axy_p = 1'b1;
        bus.mode_p   = ~md;
        bus.a_p      = AW'(777);
        bus.x_p      = DW'(-x);
        bus.y_p      = DW'(55);
      end else begin
        bus.wr_axy_p = 1'b0;
      end
      if (bus.rok_nxy_p === 1'b1) done = 1'b1;
    end
    chk_eq({tag, "_done"}, int'(done), 1);
    chk_eq({tag, "_lat"}, lat, exp_lat);
    nxo = $signed(bus.nx_p);
    nyo = $signed(bus.ny_p);
    nao = $signed(bus.na_p);
    chk_tol({tag, "_nx"}, nxo, ex, tol_xy);
    chk_tol({tag, "_ny"}, nyo, ey, tol_xy);
    chk_tol({tag, "_na"}, nao, ea, tol_a);
    for (int h = 0; h < hold; h++) begin
      @(posedge ck);
      #1;
      chk_eq({tag, "_hold_rok"}, int'(bus.rok_nxy_p), 1);
      chk_eq({tag, "_hold_nx"}, int'($signed(bus.nx_p)), nxo);
      chk_eq({tag, "_hold_na"}, int'($signed(bus.na_p)), nao);
    end
    @(negedge ck);
    bus.rd_nxy_p = 1'b1;
    @(posedge ck);
    #1;
    bus.rd_nxy_p = 1'b0;
    chk_eq({tag, "_rd_wok"}, int'(bus.wok_axy_p), 1);
    chk_eq({tag, "_rd_rok"}, int'(bus.rok_nxy_p), 0);
  endtask

  initial begin
    int  nxo, pulses;
    real p;
    gain = 1.0;
    p    = 1.0;
    for (int k = 0; k < NITER; k++) begin
      gain = gain * $sqrt(1.0 + p);
      p    = p * 0.25;
    end
    gain = gain * 0.6015625;

    bus.wr_axy_p = 1'b0;
    bus.mode_p   = 1'b0;
    bus.a_p      = '0;
    bus.x_p      = '0;
    bus.y_p      = '0;
    bus.rd_nxy_p = 1'b0;
    raz          = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    chk_eq("rst_wok", int'(bus.wok_axy_p), 1);
    chk_eq("rst_rok", int'(bus.rok_nxy_p), 0);
    chk_eq("rst_nx", int'(bus.nx_p), 0);
    chk_eq("rst_ny", int'(bus.ny_p), 0);
    chk_eq("rst_na", int'(bus.na_p), 0);
    raz = 1'b1;

    run_txn("rot_a0", 1'b0, 0, 100, 0, 2, 2, 1'b0, 10, nxo);
    run_txn("rot_a201", 1'b0, 201, 100, 0, 2, 2, 1'b0, 0, nxo);
    run_txn("rot_a804", 1'b0, 804, 50, 0, 2, 2, 1'b0, 0, nxo);
    run_txn("rot_a1023", 1'b0, 1023, 60, 0, 3, 2, 1'b0, 0, nxo);
    run_txn("vec_0_100", 1'b1, 0, 0, 100, 2, 2, 1'b0, 0, nxo);
    run_txn("vec_m100_0", 1'b1, 0, -100, 0, 2, 2, 1'b0, 0, nxo);
    run_txn("vec_m50_m50", 1'b1, 0, -50, -50, 2, 2, 1'b0, 0, nxo);
    run_txn("vec_sat", 1'b1, 0, -128, -128, 2, 2, 1'b0, 0, nxo);
    chk_eq("vec_sat_nx127", nxo, 127);
    run_txn("rot_inject", 1'b0, 100, 70, -30, 3, 2, 1'b1, 0, nxo);

    // reset while the engine is iterating
    @(negedge ck);
    bus.wr_axy_p = 1'b1;
    bus.mode_p   = 1'b0;
    bus.a_p      = AW'(300);
    bus.x_p      = DW'(40);
    bus.y_p      = DW'(20);
    @(posedge ck);
    #1;
    bus.wr_axy_p = 1'b0;
    repeat (5) @(posedge ck);
    @(negedge ck);
    raz = 1'b0;
    @(negedge ck);
    chk_eq("midrst_wok", int'(bus.wok_axy_p), 1);
    chk_eq("midrst_rok", int'(bus.rok_nxy_p), 0);
    chk_eq("midrst_nx", int'(bus.nx_p), 0);
    chk_eq("midrst_na", int'(bus.na_p), 0);
    raz    = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge ck);
      if (bus.rok_nxy_p === 1'b1) pulses++;
    end
    chk_eq("midrst_no_rok", pulses, 0);

    for (int n = 0; n < 24; n++) begin
      bit md;
      int ra, rx, ry;
      md = 1'($urandom_range(0, 1));
      ra = int'($urandom_range(0, 1023));
      rx = int'($urandom_range(0, 160)) - 80;
      ry = int'($urandom_range(0, 160)) - 80;
      if (rx > -8 && rx < 8 && ry > -8 && ry < 8) rx = 40;
      run_txn($sformatf("rnd%0d", n), md, ra, rx, ry, 3, 3, 1'b0, 0, nxo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_gen.md
Name: cordic_gen

Overview:
Multi-cycle, parametrised CORDIC engine with two modes: rotation (rotate (x,y) by angle a) and vectoring (return the magnitude and angle of (x,y)).
- Operands enter through a write handshake; results leave through a read handshake.
- Single iterative datapath: one micro-rotation per cycle, gain compensated by shift-add, saturated outputs.
- Successor of the fixed 8-bit rotation-only engine; adds data-width and iteration-count parameters, vectoring mode, an angle output and output saturation.

Parameters:
DW, 8, signed data width of x/y in and out (4..16)
AW, 10, angle port width (10..14); angle fixed-point scale is 2^7 (pi/2 = 201, pi = 402)
NITER, 8, CORDIC iterations (4..12)

Ports:
ck  in  1  clock, all state on rising edge
raz  in  1  synchronous active-low reset
wr_axy_p  in  1  operand valid
mode_p  in  1  0 = rotation, 1 = vectoring; sampled with operands
a_p  in  AW  rotation angle, unsigned; ignored in vectoring
x_p  in  DW  signed x
y_p  in  DW  signed y
wok_axy_p  out  1  ready for operands (state GET)
rd_nxy_p  in  1  result consumed
nx_p  out  DW  rotation: x'; vectoring: magnitude
ny_p  out  DW  rotation: y'; vectoring: residual y
na_p  out  AW  vectoring: signed angle; rotation: residual angle
rok_nxy_p  out  1  result valid (state PUT)

Behaviour:
Reset and encoding
- Reset is synchronous, active-low, on ck only. raz=0 at an edge -> state GET, quadrant=0, i=0, all data registers 0.
- After reset: wok_axy_p=1, rok_nxy_p=0, nx_p=ny_p=na_p=0.
- Reset overrides any state, including mid-CALC; a partial result is discarded.
- Internal x/y width IW = DW+9: operand placed as sign-extended DW bits above 7 fraction bits. Internal angle width AW+2, two's complement.

State machine (one-hot): GET, NORM, CALC, MKC, PLACE, PUT.
- GET: wok=1. wr_axy_p=1 latches a (zero-extended), x, y and mode; clears quadrant and i; goes to NORM. Otherwise stays in GET.
- NORM, rotation: if a-201 >= 0, set a=a-201, increment quadrant mod 4 and stay in NORM. Else go to CALC. Duration is floor(a/201)+1 cycles.
- NORM, vectoring: exactly 1 cycle.
  - If x<0: negate x and y; a = +402 if y>=0, else -402.
  - If x>=0: a = 0.
  - Then go to CALC.
- CALC: NITER cycles, with i = 0..NITER-1.
  - Rotation, direction d = sign(a): a>=0 -> x-=y>>>i, y+=x>>>i, a-=atan(i). a<0 -> the opposite signs.
  - Vectoring, d = -sign(y): y>=0 -> x+=y>>>i, y-=x>>>i, a+=atan(i). y<0 -> the opposite signs.
  - All updates use pre-update values; >>> is arithmetic shift.
  - atan table, i=0..11: 100, 59, 31, 16, 8, 4, 2, 1, 0, 0, 0, 0.
  - After the last iteration, clear i and go to MKC.
- MKC: 3 cycles computing xkc = (x>>>7)+(x>>>5), then +(x>>>4), then +(x>>>1) (gain ~0.6016); same for ykc. Then go to PLACE.
- PLACE, 1 cycle. Rotation, by quadrant:
  - q0: (xkc, ykc)
  - q1: (-ykc, xkc)
  - q2: (-xkc, -ykc)
  - q3: (ykc, -xkc)
  - Vectoring: (xkc, ykc).
  - Then go to PUT.
- PUT: rok=1; outputs stable and held. rd_nxy_p=1 -> GET on the next cycle. A new operand is accepted no earlier than the cycle after that.

Outputs
- nx_p/ny_p: internal bits [DW+6:7], saturated to [-2^(DW-1), 2^(DW-1)-1].
- na_p: a saturated to the signed AW range.
- Outputs are registered and change only on the PLACE->PUT edge.

Timing and flow control
- Latency from the accepting edge to rok=1: rotation k+NITER+6 cycles (k = floor(a/201)); vectoring NITER+6 cycles.
- wr_axy_p outside GET is ignored and the operands are not latched. rd_nxy_p outside PUT is ignored.
- Angle inputs up to 2^AW-1 are allowed; quadrant wraps mod 4.

Test Plan:
Defaults DW=8, AW=10, NITER=8; tolerance +/-2 LSB.
1. Reset: raz=0 for 2 cycles, then 1 -> wok=1, rok=0, nx=ny=na=0. Reset asserted during CALC -> wok=1 the next cycle; no rok pulse.
2. Rotation: a=0, x=100, y=0 -> nx~99, ny~0, rok exactly 14 cycles after acceptance. a=201, x=100, y=0 -> nx~0, ny~99, latency 15.
3. Rotation wrap: a=804, x=50, y=0 -> 4 quadrant steps, quadrant=0, nx~50, ny~0. a=1023 accepted without hang.
4. Vectoring: x=0, y=100 -> nx~99, na~201. x=-100, y=0 -> nx~99, na~402. x=-50, y=-50 -> nx~70, na~-302.
5. Saturation: vectoring x=y=-128 -> nx=127 (saturated), na~-302.
6. Handshake: hold rd_nxy_p=0 for 10 cycles in PUT -> rok and outputs stable. wr_axy_p pulsed during CALC -> ignored. rd_nxy_p=1 -> wok=1 the next cycle. Back-to-back transactions give correct results.
